// File: rtl/input_ctrl_if.sv
// AXI4-Stream sample bus between an upstream source and the FFT input
// controller. The controller is the slave; it only drives tready.
interface input_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/input_ctrl.sv
// FFT input controller: receives one frame of complex samples over AXIS,
// stores each sample at the (optionally bit-reversed) address of its arrival
// index, then holds the frame and serves two read ports until released.
module input_ctrl #(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int BIT_REVERSE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             release_req,
  output logic             load_done,
  output logic             frame_err,
  output logic             busy,
  input_ctrl_if.slave      s_axis,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx1,
  input  logic [AW-1:0]    rd_idx2,
  output logic [WIDTH-1:0] rd_x1,
  output logic [WIDTH-1:0] rd_x2
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            done_n, err_n;
  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  // Reverse all AW address bits (decimation-in-time input ordering).
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Ready and busy decode purely from the registered state, so there is no
  // combinational path from tvalid back to tready.
  assign s_axis.tready = (state == LOAD);
  assign busy          = (state != IDLE);
  assign accept        = s_axis.tvalid && (state == LOAD);
  assign wr_addr       = (BIT_REVERSE != 0) ? bitrev(cnt) : cnt;

  // Next-state, beat counter and completion/error pulse decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt == LAST_IDX) begin
            // A full frame completes even without tlast; the missing marker
            // is reported alongside load_done.
            state_n = HOLD;
            cnt_n   = '0;
            done_n  = 1'b1;
            err_n   = !s_axis.tlast;
          end else if (s_axis.tlast) begin
            // Short frame: drop it and restart counting on the next beat.
            cnt_n = '0;
            err_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        // release has priority; a simultaneous load_start is simply dropped.
        if (release_req) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers: state, beat counter and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      load_done <= done_n;
      frame_err <= err_n;
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= s_axis.tdata;
    end
  end

  // Dual read ports, one-cycle latency, outputs hold while rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_x1 <= '0;
      rd_x2 <= '0;
    end else if (rd_en) begin
      rd_x1 <= mem[rd_idx1];
      rd_x2 <= mem[rd_idx2];
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Self-checking bench for input_ctrl with a frame-level reference model.
module tb_input_ctrl;

  localparam int W = 64;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        release_req;
  logic        load_done;
  logic        frame_err;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rd_idx1;
  logic [7:0]  rd_idx2;
  logic [W-1:0] rd_x1;
  logic [W-1:0] rd_x2;

  input_ctrl_if #(.WIDTH(W)) s_axis ();

  input_ctrl #(
    .WIDTH(W), .DEPTH(N), .AW(8), .BIT_REVERSE(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .release_req(release_req),
    .load_done  (load_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .s_axis     (s_axis),
    .rd_en      (rd_en),
    .rd_idx1    (rd_idx1),
    .rd_idx2    (rd_idx2),
    .rd_x1      (rd_x1),
    .rd_x2      (rd_x2)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: expected RAM image and index within the current frame.
  logic [W-1:0] ref_mem [N];
  int           m_idx;

  function automatic int rev8(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 8; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pair(input int v);
    return {32'(v), 32'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_idx = 0;
  endtask

  task automatic pulse_release();
    release_req = 1'b1;
    tick();
    release_req = 1'b0;
  endtask

  task automatic rd2(input int a1, input int a2,
                     output logic [W-1:0] x1, output logic [W-1:0] x2);
    rd_en   = 1'b1;
    rd_idx1 = 8'(a1);
    rd_idx2 = 8'(a2);
    tick();
    rd_en = 1'b0;
    x1 = rd_x1;
    x2 = rd_x2;
  endtask

  // Drives nbeats accepted beats. mode 0: data {base+i, base+i}; mode 1: random.
  // tlast is set on beat index tlast_at (-1 = never). Status pulses are tallied.
  task automatic drive_beats(input int nbeats, input int tlast_at, input bit gaps,
                             input int mode, input int base,
                             output int ndone, output int nerr, output int nboth,
                             output int done_tick, output bit timeout);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    logic [W-1:0] d;
    ndone = 0; nerr = 0; nboth = 0; done_tick = -1;
    while (i < nbeats && guard < 4000) begin
      d = (mode == 0) ? pair(base + i) : {$urandom(), $urandom()};
      s_axis.tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis.tdata  = d;
      s_axis.tlast  = (i == tlast_at);
      acc = s_axis.tvalid && s_axis.tready;
      tick();
      guard++;
      if (load_done) begin
        ndone++;
        if (done_tick < 0) done_tick = guard;
      end
      if (frame_err) nerr++;
      if (load_done && frame_err) nboth++;
      if (acc) begin
        ref_mem[rev8(m_idx)] = d;
        if (m_idx == N - 1 || i == tlast_at) m_idx = 0;
        else m_idx++;
        i++;
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    timeout = (i < nbeats);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (s_axis.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b want 0", s_axis.tready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b want 0", load_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (rd_x1 !== '0) begin n_fail++; $display("FAIL reset_rd_x1 got %h want 0", rd_x1); end
    n_cmp++; if (rd_x2 !== '0) begin n_fail++; $display("FAIL reset_rd_x2 got %h want 0", rd_x2); end
  endtask

  task automatic test_basic_load();
    int nd, ne, nb, dt;
    bit to;
    logic [W-1:0] x1, x2;
    pulse_start();
    n_cmp++; if (s_axis.tready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_tready_rise got tready=%b busy=%b want 1/1", s_axis.tready, busy); end
    drive_beats(N, N - 1, 1'b0, 0, 0, nd, ne, nb, dt, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", to); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", nd); end
    n_cmp++; if (dt !== N) begin n_fail++; $display("FAIL basic_done_latency got %0d want %0d", dt, N); end
    n_cmp++; if (ne !== 0) begin n_fail++; $display("FAIL basic_frame_err got %0d want 0", ne); end
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_hold got tready=%b busy=%b want 0/1", s_axis.tready, busy); end
    // Read issued in the first HOLD cycle sees the last written word.
    rd2(0, 255, x1, x2);
    n_cmp++; if (x2 !== pair(255)) begin n_fail++; $display("FAIL basic_first_hold_read got %h want %h", x2, pair(255)); end
    n_cmp++; if (x1 !== pair(0)) begin n_fail++; $display("FAIL basic_addr0 got %h want %h", x1, pair(0)); end
    rd2(1, 255, x1, x2);
    n_cmp++; if (x1 !== pair(128)) begin n_fail++; $display("FAIL basic_addr1 got %h want %h", x1, pair(128)); end
    rd2(3, 255, x1, x2);
    n_cmp++; if (x1 !== pair(192)) begin n_fail++; $display("FAIL basic_addr3 got %h want %h", x1, pair(192)); end
    n_cmp++; if (x2 !== pair(255)) begin n_fail++; $display("FAIL basic_addr255 got %h want %h", x2, pair(255)); end
    // With rd_en low the outputs keep the last read data.
    rd_idx1 = 8'd7;
    tick();
    tick();
    n_cmp++; if (rd_x1 !== pair(192)) begin n_fail++; $display("FAIL basic_rd_hold got %h want %h", rd_x1, pair(192)); end
    pulse_release();
    n_cmp++; if (busy !== 1'b0 || s_axis.tready !== 1'b0) begin n_fail++; $display("FAIL basic_release got busy=%b tready=%b want 0/0", busy, s_axis.tready); end
  endtask

  task automatic test_gaps();
    int nd, ne, nb, dt, bad;
    bit to;
    logic [W-1:0] x1, x2;
    pulse_start();
    drive_beats(N, N - 1, 1'b1, 0, 0, nd, ne, nb, dt, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL gaps_timeout got %b want 0", to); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL gaps_done_count got %0d want 1", nd); end
    n_cmp++; if (ne !== 0) begin n_fail++; $display("FAIL gaps_frame_err got %0d want 0", ne); end
    bad = 0;
    for (int a = 0; a < N; a++) begin
      rd2(a, N - 1 - a, x1, x2);
      n_cmp++; if (x1 !== pair(rev8(a))) begin n_fail++; bad++; if (bad < 5) $display("FAIL gaps_image_p1[%0d] got %h want %h", a, x1, pair(rev8(a))); end
      n_cmp++; if (x2 !== ref_mem[N - 1 - a]) begin n_fail++; bad++; if (bad < 5) $display("FAIL gaps_image_p2[%0d] got %h want %h", N - 1 - a, x2, ref_mem[N - 1 - a]); end
    end
    pulse_release();
  endtask

  task automatic test_short_frame();
    int nd, ne, nb, dt, bad;
    bit to;
    logic [W-1:0] x1, x2;
    pulse_start();
    drive_beats(100, 99, 1'b0, 1, 0, nd, ne, nb, dt, to);
    n_cmp++; if (ne !== 1 || nd !== 0) begin n_fail++; $display("FAIL short_pulses got err=%0d done=%0d want 1/0", ne, nd); end
    n_cmp++; if (s_axis.tready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL short_stays_load got tready=%b busy=%b want 1/1", s_axis.tready, busy); end
    drive_beats(N, N - 1, 1'b1, 0, 1000, nd, ne, nb, dt, to);
    n_cmp++; if (to !== 1'b0 || nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL short_next_frame got to=%b done=%0d err=%0d want 0/1/0", to, nd, ne); end
    rd2(0, 1, x1, x2);
    n_cmp++; if (x1 !== pair(1000)) begin n_fail++; $display("FAIL short_addr0 got %h want %h", x1, pair(1000)); end
    bad = 0;
    for (int a = 0; a < N; a++) begin
      rd2(a, a, x1, x2);
      n_cmp++; if (x1 !== ref_mem[a]) begin n_fail++; bad++; if (bad < 5) $display("FAIL short_image[%0d] got %h want %h", a, x1, ref_mem[a]); end
    end
    pulse_release();
  endtask

  task automatic test_missing_tlast();
    int nd, ne, nb, dt;
    bit to;
    pulse_start();
    drive_beats(N, -1, 1'b0, 1, 0, nd, ne, nb, dt, to);
    n_cmp++; if (to !== 1'b0 || nd !== 1) begin n_fail++; $display("FAIL notlast_done got to=%b done=%0d want 0/1", to, nd); end
    n_cmp++; if (ne !== 1 || nb !== 1) begin n_fail++; $display("FAIL notlast_err_same_cycle got err=%0d both=%0d want 1/1", ne, nb); end
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL notlast_hold got tready=%b busy=%b want 0/1", s_axis.tready, busy); end
  endtask

  task automatic test_control_priority();
    // Entered in HOLD from the previous scenario.
    pulse_start();
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL prio_start_in_hold got tready=%b busy=%b want 0/1", s_axis.tready, busy); end
    tick();
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL prio_start_in_hold2 got tready=%b busy=%b want 0/1", s_axis.tready, busy); end
    load_start  = 1'b1;
    release_req = 1'b1;
    tick();
    load_start  = 1'b0;
    release_req = 1'b0;
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_release_wins got tready=%b busy=%b want 0/0", s_axis.tready, busy); end
    tick();
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_start_dropped got tready=%b busy=%b want 0/0", s_axis.tready, busy); end
  endtask

  task automatic test_reset_mid_frame();
    int nd, ne, nb, dt, bad;
    bit to;
    logic [W-1:0] x1, x2;
    pulse_start();
    drive_beats(51, -1, 1'b0, 1, 0, nd, ne, nb, dt, to);
    n_cmp++; if (s_axis.tready !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got tready=%b want 1", s_axis.tready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_immediate got tready=%b busy=%b want 0/0", s_axis.tready, busy); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (s_axis.tready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got tready=%b busy=%b want 0/0", s_axis.tready, busy); end
    pulse_start();
    drive_beats(N, N - 1, 1'b1, 1, 0, nd, ne, nb, dt, to);
    n_cmp++; if (to !== 1'b0 || nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL midrst_reload got to=%b done=%0d err=%0d want 0/1/0", to, nd, ne); end
    bad = 0;
    for (int a = 0; a < N; a++) begin
      rd2(a, N - 1 - a, x1, x2);
      n_cmp++; if (x1 !== ref_mem[a]) begin n_fail++; bad++; if (bad < 5) $display("FAIL midrst_image[%0d] got %h want %h", a, x1, ref_mem[a]); end
    end
    pulse_release();
  endtask

  initial begin
    rst           = 1'b1;
    load_start    = 1'b0;
    release_req   = 1'b0;
    rd_en         = 1'b0;
    rd_idx1       = '0;
    rd_idx2       = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    m_idx         = 0;
    for (int a = 0; a < N; a++) ref_mem[a] = '0;

    test_reset();
    test_basic_load();
    test_gaps();
    test_short_frame();
    test_missing_tlast();
    test_control_priority();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/input_ctrl.md
# input_ctrl

AXI4-Stream slave front end of the FFT datapath. It accepts one 256-point frame of complex samples, {imag, real} Q24.8, and writes them into a 256x64 sample RAM. Each sample goes to the bit-reversed address of its arrival index. When the frame is complete, the block holds the frame and serves the butterfly engine through two independent read ports until released. It is the receive-side counterpart of the output controller that streams results out.

## Interface
Parameters:
- WIDTH, 64: sample width in bits, {imag[63:32], real[31:0]}.
- DEPTH, 256: points per frame.
- AW, 8: address width, log2(DEPTH).
- BIT_REVERSE, 1: 1 = write to bitrev(index); 0 = write to index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle request to begin receiving a frame.
- release  in  1  single-cycle indication that the frame is consumed; buffer is freed.
- load_done  out  1  one-cycle pulse when the last sample of a frame is written.
- frame_err  out  1  one-cycle pulse on a framing error.
- busy  out  1  high in LOAD or HOLD.
- s_axis_tvalid  in  1  AXIS slave valid.
- s_axis_tready  out  1  AXIS slave ready.
- s_axis_tdata  in  WIDTH  sample.
- s_axis_tlast  in  1  end-of-frame marker.
- rd_en  in  1  read strobe for both ports.
- rd_idx1, rd_idx2  in  AW  read addresses.
- rd_x1, rd_x2  out  WIDTH  read data.

## Operation
- States:
  - IDLE: tready=0.
  - LOAD: tready=1, beat counter cnt active.
  - HOLD: tready=0, frame valid, reads served.
- IDLE -> LOAD on load_start; cnt cleared to 0.
- In LOAD, a beat is accepted when tvalid && tready. On acceptance:
  - Write tdata to RAM[BIT_REVERSE ? bitrev(cnt) : cnt], where bitrev reverses all AW bits.
  - Then cnt = cnt+1.
- Beat with cnt == DEPTH-1 and tlast=1: normal completion. Next state HOLD; load_done pulses.
- Beat with cnt == DEPTH-1 and tlast=0: still complete to HOLD with load_done. frame_err also pulses in the same cycle as load_done.
- Beat with cnt < DEPTH-1 and tlast=1 (short frame): the beat is written and the frame is discarded. cnt returns to 0, frame_err pulses, and the state stays LOAD, so the next beat starts a new frame.
- load_start in LOAD or HOLD is ignored. release in IDLE or LOAD is ignored.
- HOLD -> IDLE on release. If load_start and release arrive in the same HOLD cycle, release wins and load_start is dropped.
- Reads:
  - rd_en=1 registers RAM[rd_idx1] -> rd_x1 and RAM[rd_idx2] -> rd_x2.
  - rd_en=0 holds rd_x1 and rd_x2.
  - Reads are honoured in any state; contents are defined only in HOLD.
- The RAM has one write port (AXIS side) and two read ports. Write and read addresses never conflict in normal operation, since reads happen only in HOLD.

## Timing
- Reset values:
  - state IDLE, cnt 0.
  - s_axis_tready, load_done, frame_err, busy all 0.
  - rd_x1, rd_x2 = 0.
  - RAM contents not cleared.
- s_axis_tready is decoded from the registered state, with no combinational path from tvalid.
- The load_start edge moves the state to LOAD; tready is 1 from the next cycle. Full throughput is 1 beat/cycle, so a back-to-back frame takes 256 cycles.
- The last beat is accepted at edge N. State is HOLD and load_done=1 after edge N, for exactly one cycle. tready=0 in that same cycle.
- The word written at edge N is readable via rd_en in the first HOLD cycle (write-before-read across edges).
- Read latency: 1 cycle. rd_en at edge M gives data valid after edge M.
- busy tracks state with no extra latency.
- Reset mid-frame: immediate return to IDLE with tready=0; the partial frame is abandoned.

## Test plan
- Basic load:
  - Stimulus: load_start, then 256 beats, tdata = {i, i} for i=0..255, tlast on i=255, tvalid constant.
  - Response: load_done exactly once, 256 cycles after tready rises.
  - Read check: rd_idx1=1 returns {128,128}; rd_idx1=3 returns {192,192}; rd_idx2=255 returns {255,255}.
- Backpressure-free gaps: tvalid toggled randomly on 256 beats -> identical RAM image to the basic-load test; no frame_err.
- Short frame: tlast on beat 99 -> frame_err pulse, state stays LOAD. A following 256-beat frame with data=i+1000 -> load_done; address 0 holds {1000,1000}.
- Missing tlast: 256 beats with tlast=0 -> load_done and frame_err in the same cycle; state HOLD.
- Control priority:
  - load_start during HOLD: ignored, tready stays 0.
  - release together with load_start in HOLD: state IDLE next cycle, tready stays 0.
- Reset mid-frame: assert rst after beat 50 -> tready=0 and busy=0 immediately. A new load_start and full frame then completes normally with load_done.
